// File: rtl/ec_scalar_ctrl.sv
// Left-to-right double-and-add sequencer for k*P; point arithmetic is delegated to an external unit.
// One operation in flight at a time, any completion latency; start requests are ignored while busy.
`ifndef MAX_BITS
`define MAX_BITS 256
`endif

module ec_scalar_ctrl #(
  parameter int NBITS = `MAX_BITS
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [NBITS-1:0] i_k,
  input  logic [NBITS-1:0] i_px,
  input  logic [NBITS-1:0] i_py,
  output logic             o_op_start,
  output logic             o_op_add,
  output logic [NBITS-1:0] o_op_x1,
  output logic [NBITS-1:0] o_op_y1,
  output logic [NBITS-1:0] o_op_x2,
  output logic [NBITS-1:0] o_op_y2,
  input  logic             i_op_done,
  input  logic [NBITS-1:0] i_op_x,
  input  logic [NBITS-1:0] i_op_y,
  output logic             o_busy,
  output logic             o_finished,
  output logic [NBITS-1:0] o_result_x,
  output logic [NBITS-1:0] o_result_y
);

  localparam int IW = (NBITS > 1) ? $clog2(NBITS) : 1;
  localparam logic [IW-1:0] IDX_TOP = IW'(NBITS - 1);

  typedef enum logic [2:0] {
    IDLE, SCAN, DBL, DBL_W, ADD, ADD_W, NEXT, DONE
  } state_t;

  state_t           state_q;
  logic [NBITS-1:0] k_q, px_q, py_q, rx_q, ry_q;
  logic [NBITS-1:0] res_x_q, res_y_q;
  logic [IW-1:0]    idx_q;
  logic             op_start_q, op_add_q, busy_q, fin_q;
  logic             k_bit_d;

  assign k_bit_d = k_q[idx_q];

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= IDLE;
      k_q        <= '0;
      px_q       <= '0;
      py_q       <= '0;
      rx_q       <= '0;
      ry_q       <= '0;
      res_x_q    <= '0;
      res_y_q    <= '0;
      idx_q      <= '0;
      op_start_q <= 1'b0;
      op_add_q   <= 1'b0;
      busy_q     <= 1'b0;
      fin_q      <= 1'b0;
    end else begin
      op_start_q <= 1'b0;
      fin_q      <= 1'b0;
      case (state_q)
        IDLE: begin
          if (i_start) begin
            k_q     <= i_k;
            px_q    <= i_px;
            py_q    <= i_py;
            idx_q   <= IDX_TOP;
            busy_q  <= 1'b1;
            state_q <= SCAN;
          end
        end
        SCAN: begin
          if (k_bit_d) begin
            rx_q    <= px_q;
            ry_q    <= py_q;
            state_q <= NEXT;
          end else if (idx_q == '0) begin
            // k = 0: result is the point at infinity (x all-ones, y zero)
            rx_q    <= '1;
            ry_q    <= '0;
            res_x_q <= '1;
            res_y_q <= '0;
            fin_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q <= idx_q - 1'b1;
          end
        end
        NEXT: begin
          if (idx_q == '0) begin
            res_x_q <= rx_q;
            res_y_q <= ry_q;
            fin_q   <= 1'b1;
            state_q <= DONE;
          end else begin
            idx_q      <= idx_q - 1'b1;
            op_start_q <= 1'b1;
            op_add_q   <= 1'b0;
            state_q    <= DBL;
          end
        end
        DBL:   state_q <= DBL_W;
        DBL_W: begin
          if (i_op_done) begin
            rx_q <= i_op_x;
            ry_q <= i_op_y;
            if (k_bit_d) begin
              op_start_q <= 1'b1;
              op_add_q   <= 1'b1;
              state_q    <= ADD;
            end else begin
              state_q <= NEXT;
            end
          end
        end
        ADD:   state_q <= ADD_W;
        ADD_W: begin
          if (i_op_done) begin
            rx_q    <= i_op_x;
            ry_q    <= i_op_y;
            state_q <= NEXT;
          end
        end
        DONE: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_op_start = op_start_q;
  assign o_op_add   = op_add_q;
  assign o_op_x1    = rx_q;
  assign o_op_y1    = ry_q;
  assign o_op_x2    = px_q;
  assign o_op_y2    = py_q;
  assign o_busy     = busy_q;
  assign o_finished = fin_q;
  assign o_result_x = res_x_q;
  assign o_result_y = res_y_q;

endmodule

// File: tb/tb_ec_scalar_ctrl.sv
// Directed bench for ec_scalar_ctrl with a mock point unit (dbl: 2x+1, y+3; add: x1+x2, y1^y2).
module tb_ec_scalar_ctrl;
  localparam int NB = 8;

  logic          i_clk = 1'b0;
  logic          i_rst, i_start;
  logic [NB-1:0] i_k, i_px, i_py;
  logic          i_op_done = 1'b0;
  logic [NB-1:0] i_op_x = '0, i_op_y = '0;
  logic          o_op_start, o_op_add, o_busy, o_finished;
  logic [NB-1:0] o_op_x1, o_op_y1, o_op_x2, o_op_y2, o_result_x, o_result_y;

  ec_scalar_ctrl #(.NBITS(NB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start),
    .i_k(i_k), .i_px(i_px), .i_py(i_py),
    .o_op_start(o_op_start), .o_op_add(o_op_add),
    .o_op_x1(o_op_x1), .o_op_y1(o_op_y1), .o_op_x2(o_op_x2), .o_op_y2(o_op_y2),
    .i_op_done(i_op_done), .i_op_x(i_op_x), .i_op_y(i_op_y),
    .o_busy(o_busy), .o_finished(o_finished),
    .o_result_x(o_result_x), .o_result_y(o_result_y)
  );

  always #5 i_clk = ~i_clk;

  int checks = 0;
  int errors = 0;
  int ops_n = 0;
  int fin_n = 0;
  int lat = 3;
  bit stab_en = 1'b1;
  int stab_bad = 0;
  logic          add_log [64];
  logic [NB-1:0] x1_log [64];

  // mock point unit and output monitor, sampled on the falling edge
  bit            pend = 1'b0;
  int            cnt = 0;
  logic          s_add;
  logic [NB-1:0] s_x1, s_y1, s_x2, s_y2, m_x, m_y;

  always @(negedge i_clk) begin
    i_op_done = 1'b0;
    if (o_finished) fin_n++;
    if (pend) begin
      if (stab_en && (o_op_x1 !== s_x1 || o_op_y1 !== s_y1 || o_op_x2 !== s_x2 ||
                      o_op_y2 !== s_y2 || o_op_add !== s_add)) stab_bad++;
      cnt--;
      if (cnt <= 0) begin
        i_op_done = 1'b1;
        i_op_x    = m_x;
        i_op_y    = m_y;
        pend      = 1'b0;
      end
    end
    if (o_op_start) begin
      if (pend) stab_bad++;
      if (ops_n < 64) begin
        add_log[ops_n] = o_op_add;
        x1_log[ops_n]  = o_op_x1;
      end
      ops_n++;
      s_add = o_op_add; s_x1 = o_op_x1; s_y1 = o_op_y1; s_x2 = o_op_x2; s_y2 = o_op_y2;
      if (o_op_add) begin
        m_x = o_op_x1 + o_op_x2;
        m_y = o_op_y1 ^ o_op_y2;
      end else begin
        m_x = o_op_x1 + o_op_x1 + 8'd1;
        m_y = o_op_y1 + 8'd3;
      end
      cnt  = lat;
      pend = 1'b1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_fin(output int cyc);
    cyc = 0;
    while (!o_finished && cyc < 400) begin
      @(negedge i_clk);
      i_start = 1'b0;
      cyc++;
    end
    chk("fin_seen", 32'(o_finished), 32'd1);
  endtask

  task automatic run(input logic [NB-1:0] k, input logic [NB-1:0] px, input logic [NB-1:0] py,
                     output int cyc);
    i_k = k; i_px = px; i_py = py; i_start = 1'b1;
    wait_fin(cyc);
  endtask

  initial begin
    int cyc, ops0, fin0, alt_bad, guard;
    i_rst = 1'b1; i_start = 1'b0; i_k = '0; i_px = '0; i_py = '0;
    repeat (3) @(negedge i_clk);

    chk("rst_busy",     32'(o_busy), 32'd0);
    chk("rst_finished", 32'(o_finished), 32'd0);
    chk("rst_op_start", 32'(o_op_start), 32'd0);
    chk("rst_op_add",   32'(o_op_add), 32'd0);
    chk("rst_res_x",    32'(o_result_x), 32'd0);
    chk("rst_res_y",    32'(o_result_y), 32'd0);
    chk("rst_x1",       32'(o_op_x1), 32'd0);
    chk("rst_y1",       32'(o_op_y1), 32'd0);
    chk("rst_x2y2",     32'({o_op_x2, o_op_y2}), 32'd0);

    // k=1, started on the first cycle after reset release
    i_rst = 1'b0;
    ops0 = ops_n; fin0 = fin_n;
    run(8'd1, 8'd5, 8'd1, cyc);
    chk("k1_cycles", 32'(cyc), 32'd10);
    chk("k1_res_x", 32'(o_result_x), 32'd5);
    chk("k1_res_y", 32'(o_result_y), 32'd1);
    repeat (3) @(negedge i_clk);
    chk("k1_ops", 32'(ops_n - ops0), 32'd0);
    chk("k1_fin_once", 32'(fin_n - fin0), 32'd1);
    chk("k1_idle_busy", 32'(o_busy), 32'd0);
    chk("k1_res_hold", 32'({o_result_x, o_result_y}), 32'h0501);

    // k=0: all scan cycles, point at infinity
    ops0 = ops_n;
    run(8'd0, 8'd9, 8'd9, cyc);
    chk("k0_cycles", 32'(cyc), 32'(NB + 1));
    chk("k0_res_x", 32'(o_result_x), 32'hFF);
    chk("k0_res_y", 32'(o_result_y), 32'h00);
    repeat (2) @(negedge i_clk);
    chk("k0_ops", 32'(ops_n - ops0), 32'd0);

    // k=5, latency 3: DBL, DBL, ADD
    lat = 3; ops0 = ops_n; stab_bad = 0;
    run(8'd5, 8'd5, 8'd1, cyc);
    chk("k5_res_x", 32'(o_result_x), 32'd28);
    chk("k5_res_y", 32'(o_result_y), 32'd6);
    repeat (2) @(negedge i_clk);
    chk("k5_ops", 32'(ops_n - ops0), 32'd3);
    chk("k5_add_seq", 32'({add_log[ops0], add_log[ops0+1], add_log[ops0+2]}), 32'b001);
    chk("k5_x1_0", 32'(x1_log[ops0]), 32'd5);
    chk("k5_x1_1", 32'(x1_log[ops0+1]), 32'd11);
    chk("k5_x1_2", 32'(x1_log[ops0+2]), 32'd23);
    chk("k5_stable", 32'(stab_bad), 32'd0);

    // k=all-ones, latency 1: strictly alternating DBL/ADD
    lat = 1; ops0 = ops_n; fin0 = fin_n; stab_bad = 0;
    run(8'hFF, 8'd5, 8'd1, cyc);
    chk("kff_res", 32'({o_result_x, o_result_y}), 32'h7A1D);
    repeat (2) @(negedge i_clk);
    chk("kff_ops", 32'(ops_n - ops0), 32'(2 * (NB - 1)));
    alt_bad = 0;
    for (int i = 0; i < 2 * (NB - 1); i++)
      if (add_log[ops0 + i] !== 1'(i % 2)) alt_bad++;
    chk("kff_alternate", 32'(alt_bad), 32'd0);
    chk("kff_fin_once", 32'(fin_n - fin0), 32'd1);
    chk("kff_stable", 32'(stab_bad), 32'd0);

    // start pulsed during DBL_W with a different k and P is ignored
    lat = 3; ops0 = ops_n;
    i_k = 8'd5; i_px = 8'd5; i_py = 8'd1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    guard = 0;
    while (ops_n == ops0 && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    chk("ign_first_op", 32'(ops_n - ops0), 32'd1);
    @(negedge i_clk);
    i_k = 8'hFF; i_px = 8'd77; i_py = 8'd66; i_start = 1'b1;
    wait_fin(cyc);
    chk("ign_res", 32'({o_result_x, o_result_y}), 32'h1C06);
    chk("ign_p_kept", 32'({o_op_x2, o_op_y2}), 32'h0501);
    repeat (2) @(negedge i_clk);
    chk("ign_ops", 32'(ops_n - ops0), 32'd3);

    // reset in ADD_W with a late completion two cycles afterwards
    lat = 3; stab_en = 1'b0;
    i_k = 8'd3; i_px = 8'd5; i_py = 8'd1; i_start = 1'b1;
    @(negedge i_clk);
    i_start = 1'b0;
    guard = 0;
    while (!(o_op_start && o_op_add) && guard < 100) begin
      @(negedge i_clk);
      guard++;
    end
    chk("rstmid_add_seen", 32'({o_op_start, o_op_add}), 32'b11);
    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    i_rst = 1'b0;
    ops0 = ops_n; fin0 = fin_n;
    repeat (5) @(negedge i_clk);
    chk("rstmid_no_op", 32'(ops_n - ops0), 32'd0);
    chk("rstmid_no_fin", 32'(fin_n - fin0), 32'd0);
    chk("rstmid_busy", 32'(o_busy), 32'd0);
    chk("rstmid_ctl", 32'({o_op_start, o_op_add, o_finished}), 32'd0);
    chk("rstmid_res", 32'({o_result_x, o_result_y}), 32'd0);
    chk("rstmid_ops", 32'({o_op_x1, o_op_y1, o_op_x2, o_op_y2}), 32'd0);
    stab_en = 1'b1;

    // recovery: k=2 is a single doubling
    ops0 = ops_n;
    run(8'd2, 8'd5, 8'd1, cyc);
    chk("k2_res", 32'({o_result_x, o_result_y}), 32'h0B04);
    repeat (2) @(negedge i_clk);
    chk("k2_ops", 32'(ops_n - ops0), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ec_scalar_ctrl.md
EC_SCALAR_CTRL -- requirements
Module: ec_scalar_ctrl

Interface
REQ-001 SHALL have parameter NBITS, default `MAX_BITS (ECCDefine.vh), the operand width of k, coordinates and modulus.
REQ-002 SHALL have port i_clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port i_rst, input, 1, synchronous active-high reset.
REQ-004 SHALL have port i_start, input, 1, a one-cycle request to compute k*P; sampled only in IDLE.
REQ-005 SHALL have port i_k, input, NBITS, the scalar; latched on accepted i_start.
REQ-006 SHALL have ports i_px and i_py, input, NBITS each, the base point P; latched on accepted i_start.
REQ-007 SHALL have port o_op_start, output, 1, a one-cycle start pulse to the point-operation unit.
REQ-008 SHALL have port o_op_add, output, 1; 0 requests doubling of R and 1 requests R+P.
REQ-009 SHALL have ports o_op_x1 and o_op_y1, output, NBITS each, the accumulator R; and ports o_op_x2 and o_op_y2, output, NBITS each, the latched P.
REQ-010 SHALL have port i_op_done, input, 1, completion pulse from the point unit; and ports i_op_x and i_op_y, input, NBITS each, its result, valid when i_op_done=1.
REQ-011 SHALL have ports o_busy (1), o_finished (1), o_result_x (NBITS) and o_result_y (NBITS), all outputs.

Function
REQ-012 SHALL encode the point at infinity as x = all-ones, y = 0.
REQ-013 SHALL implement left-to-right double-and-add: R := P at the most-significant set bit of k; then for each lower bit, double R, and add P when that bit is 1.
REQ-014 SHALL use the states IDLE, SCAN, DBL, DBL_W, ADD, ADD_W, NEXT and DONE.
REQ-015 IDLE: i_start=1 latches k, P and idx := NBITS-1, then moves to SCAN; o_busy=0 only in IDLE.
REQ-016 SCAN: examines k[idx], one bit per cycle.
- Bit is 0 and idx>0: decrement idx and stay in SCAN.
- Bit is 0 and idx=0: set R := infinity and go to DONE.
- Bit is 1: set R := P, then go to NEXT.
REQ-017 NEXT: idx=0 goes to DONE; otherwise decrement idx and go to DBL.
REQ-018 DBL: asserts o_op_start=1 and o_op_add=0 for exactly one cycle, then goes to DBL_W.
REQ-019 DBL_W: on i_op_done, R := (i_op_x, i_op_y). Then go to ADD if k[idx]=1, else to NEXT.
REQ-020 ADD: asserts o_op_start=1 and o_op_add=1 for one cycle, then goes to ADD_W; ADD_W on i_op_done sets R := result and goes to NEXT.
REQ-021 SHALL hold o_op_x1/y1/x2/y2 and o_op_add stable from the o_op_start cycle until the i_op_done cycle inclusive.
REQ-022 SHALL ignore i_op_done outside DBL_W and ADD_W.
REQ-023 SHALL tolerate any i_op_done latency of 1 cycle or more, with no timeout.
REQ-024 DONE: asserts o_finished=1 for exactly one cycle, loads o_result_x/y := R, and returns to IDLE.
REQ-025 SHALL hold o_result_x/y until the next DONE or reset.
REQ-026 SHALL ignore i_start while o_busy=1; latched k and P are unaffected.
REQ-027 SHALL store idx in a counter of ceil(log2(NBITS)) bits; idx never wraps below 0.
REQ-028 SHALL issue exactly (msb-index) doubles and (popcount(k)-1) adds for k≠0, and zero operations for k=0.
REQ-029 SHALL perform no field arithmetic; all modular work is delegated to the point unit.

Reset
REQ-030 When i_rst=1 at a clock edge, SHALL go to IDLE and clear to 0: o_op_start, o_op_add, o_busy, o_finished, o_result_x, o_result_y, R, idx and the latched k, P.
REQ-031 SHALL drive o_op_x1/y1/x2/y2 to 0 after reset.
REQ-032 Reset mid-operation SHALL abandon the computation with no o_finished pulse; a late i_op_done is ignored.
REQ-033 SHALL accept i_start on the first cycle after i_rst deasserts.

Verification
REQ-034 k=0 -> no o_op_start pulses; o_finished after NBITS SCAN cycles; result = (all-ones, 0).
REQ-035 k=1 with P=(5,1) -> no operations; result=(5,1); o_finished exactly once.
REQ-036 k=5 with a mock unit of 3-cycle latency -> operation sequence DBL, DBL, ADD (o_op_add = 0, 0, 1); o_op_x1 on each start equals the prior mock result; result equals the mock's final output.
REQ-037 k=all-ones -> NBITS-1 doubles and NBITS-1 adds, strictly alternating DBL/ADD.
REQ-038 i_start pulsed during DBL_W with different k -> ignored; original k's result is returned.
REQ-039 i_rst asserted in ADD_W, i_op_done arriving 2 cycles later -> all outputs 0, state IDLE, no o_finished, no o_op_start.
